// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions.
// XLEN, fetch access size and the memory-port owner encoding.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ARB_FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_counter.sv
// Counts consecutive data grants made while a fetch waits; flags guard_hit.
// Ports: clk, areset_n (sync, low), i_req_valid, d_grant, i_grant -> guard_hit.
module mem_arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic areset_n,
  input  logic i_req_valid,
  input  logic d_grant,
  input  logic i_grant,
  output logic guard_hit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] streak_cnt_d;
  logic [CW-1:0] streak_cnt_q;

  always_comb begin
    streak_cnt_d = streak_cnt_q;
    if (!i_req_valid || i_grant) begin
      streak_cnt_d = '0;
    end else if (d_grant && streak_cnt_q != LIMIT) begin
      streak_cnt_d = streak_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      streak_cnt_q <= '0;
    end else begin
      streak_cnt_q <= streak_cnt_d;
    end
  end

  assign guard_hit = (streak_cnt_q == LIMIT) & i_req_valid;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sync-read memory between fetch (i_*) and load/store (d_*).
// Data has priority; MEM_ARB_STARVE_GUARD_EN adds a fetch anti-starvation guard.
// Ports: i_req/i_rsp, d_req/d_rsp channels, mem_* port, clk, areset_n (sync, low).
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            areset_n,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [XLEN-1:0] i_req_addr,
  output logic            i_rsp_valid,
  output logic [XLEN-1:0] i_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic            d_req_we,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic [XLEN-1:0] d_req_wdata,
  input  logic [2:0]      d_req_funct3,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rsp_data,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  logic guard_hit;
  logic d_grant;
  logic i_grant;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .areset_n   (areset_n),
    .i_req_valid(i_req_valid),
    .d_grant    (d_grant),
    .i_grant    (i_grant),
    .guard_hit  (guard_hit)
  );
`else
  assign guard_hit = 1'b0;
`endif

  // Reset masks both grants so nothing reaches memory while held.
  assign d_grant = areset_n & d_req_valid & ~guard_hit;
  assign i_grant = areset_n & i_req_valid
                 & (~d_req_valid | guard_hit);

  assign d_req_ready = d_grant;
  assign i_req_ready = i_grant;

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = 3'b000;
    unique case (1'b1)
      d_grant: begin
        mem_en     = 1'b1;
        mem_we     = d_req_we;
        mem_addr   = d_req_addr;
        mem_wdata  = d_req_wdata;
        mem_funct3 = d_req_funct3;
      end
      i_grant: begin
        mem_en     = 1'b1;
        mem_addr   = i_req_addr;
        mem_funct3 = ARB_FETCH_FUNCT3;
      end
      default: ;
    endcase
  end

  arb_owner_e rsp_owner_d;
  arb_owner_e rsp_owner_q;
  logic       rsp_we_d;
  logic       rsp_we_q;

  always_comb begin
    rsp_owner_d = OWN_NONE;
    rsp_we_d    = 1'b0;
    if (d_grant) begin
      rsp_owner_d = OWN_D;
      rsp_we_d    = d_req_we;
    end else if (i_grant) begin
      rsp_owner_d = OWN_I;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      rsp_owner_q <= OWN_NONE;
      rsp_we_q    <= 1'b0;
    end else begin
      rsp_owner_q <= rsp_owner_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  assign i_rsp_valid = (rsp_owner_q == OWN_I);
  assign d_rsp_valid = (rsp_owner_q == OWN_D);
  assign i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
  // Stores complete with zero data.
  assign d_rsp_data  = (d_rsp_valid && !rsp_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a sync-read memory model.
// Memory returns addr+0x100 one cycle after a read.
module tb_mem_port_arbiter;
  import rv32i_pkg::*;

  logic            clk;
  logic            areset_n;
  logic            i_req_valid;
  logic            i_req_ready;
  logic [XLEN-1:0] i_req_addr;
  logic            i_rsp_valid;
  logic [XLEN-1:0] i_rsp_data;
  logic            d_req_valid;
  logic            d_req_ready;
  logic            d_req_we;
  logic [XLEN-1:0] d_req_addr;
  logic [XLEN-1:0] d_req_wdata;
  logic [2:0]      d_req_funct3;
  logic            d_rsp_valid;
  logic [XLEN-1:0] d_rsp_data;
  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] mem_rdata;

  int n_chk;
  int n_fail;
  logic hs_off;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_req_funct3(d_req_funct3),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_funct3  (mem_funct3),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr + 32'h100;
  end

  // Requesters must hold valid and payload until accepted.
  a_d_hold: assert property (@(posedge clk) disable iff (!areset_n || hs_off)
    (d_req_valid && !d_req_ready) |=> (d_req_valid && $stable(d_req_addr)
      && $stable(d_req_we) && $stable(d_req_wdata)));
  a_i_hold: assert property (@(posedge clk) disable iff (!areset_n || hs_off)
    (i_req_valid && !i_req_ready) |=> (i_req_valid && $stable(i_req_addr)));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    d_req_valid  = 1'b0;
    d_req_we     = 1'b0;
    d_req_addr   = '0;
    d_req_wdata  = '0;
    d_req_funct3 = 3'b000;
  endtask

  task automatic test_reset();
    hs_off = 1'b1;
    areset_n = 1'b0;
    idle_inputs();
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({i_req_ready, d_req_ready, mem_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready got=%b want=000", {i_req_ready, d_req_ready, mem_en});
    end
    step();
    @(negedge clk);
    n_chk++;
    if ({i_rsp_valid, d_rsp_valid, mem_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_rsp got=%b want=000", {i_rsp_valid, d_rsp_valid, mem_en});
    end
    step();
    idle_inputs();
    areset_n = 1'b1;
    step();
    hs_off = 1'b0;
  endtask

  task automatic test_fetch_only();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0;
    addrs[1] = 32'h4;
    addrs[2] = 32'h8;
    for (int k = 0; k < 4; k++) begin
      i_req_valid = (k < 3);
      i_req_addr  = (k < 3) ? addrs[k] : '0;
      @(negedge clk);
      if (k < 3) begin
        n_chk++;
        if (i_req_ready !== 1'b1 || mem_addr !== addrs[k] ||
            mem_funct3 !== 3'b010 || mem_en !== 1'b1) begin
          n_fail++;
          $display("FAIL fetch_grant%0d rdy=%b addr=%h f3=%b want 1 %h 010",
                   k, i_req_ready, mem_addr, mem_funct3, addrs[k]);
        end
      end
      n_chk++;
      if (k == 0) begin
        if (i_rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_rsp0 valid=%b want 0", i_rsp_valid);
        end
      end else if (i_rsp_valid !== 1'b1 ||
                   i_rsp_data !== addrs[k-1] + 32'h100) begin
        n_fail++;
        $display("FAIL fetch_rsp%0d valid=%b data=%h want 1 %h",
                 k, i_rsp_valid, i_rsp_data, addrs[k-1] + 32'h100);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    d_req_addr   = 32'h40;
    d_req_funct3 = 3'b100;
    i_req_valid  = 1'b1;
    i_req_addr   = 32'h10;
    @(negedge clk);
    n_chk++;
    if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0 ||
        mem_addr !== 32'h40 || mem_funct3 !== 3'b100) begin
      n_fail++;
      $display("FAIL coll_grant d=%b i=%b addr=%h f3=%b want 1 0 40 100",
               d_req_ready, i_req_ready, mem_addr, mem_funct3);
    end
    step();
    d_req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (i_req_ready !== 1'b1 || d_rsp_valid !== 1'b1 ||
        d_rsp_data !== 32'h140 || i_rsp_valid !== 1'b0 ||
        mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL coll_second irdy=%b dv=%b dd=%h iv=%b addr=%h want 1 1 140 0 10",
               i_req_ready, d_rsp_valid, d_rsp_data, i_rsp_valid, mem_addr);
    end
    step();
    i_req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h110 ||
        d_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_third iv=%b id=%h dv=%b want 1 110 0",
               i_rsp_valid, i_rsp_data, d_rsp_valid);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_store();
    d_req_valid  = 1'b1;
    d_req_we     = 1'b1;
    d_req_addr   = 32'h80;
    d_req_wdata  = 32'hDEADBEEF;
    d_req_funct3 = 3'b010;
    @(negedge clk);
    n_chk++;
    if (d_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL store_grant rdy=%b en=%b we=%b wd=%h a=%h want 1 1 1 deadbeef 80",
               d_req_ready, mem_en, mem_we, mem_wdata, mem_addr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL store_rsp dv=%b dd=%h we=%b want 1 0 0",
               d_rsp_valid, d_rsp_data, mem_we);
    end
    step();
  endtask

  task automatic test_starvation();
    logic exp_i;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    d_req_addr   = 32'h200;
    d_req_funct3 = 3'b010;
    i_req_valid  = 1'b1;
    i_req_addr   = 32'h300;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_i = ((k % 5) == 4);
`else
      exp_i = 1'b0;
`endif
      @(negedge clk);
      n_chk++;
      if (i_req_ready !== exp_i || d_req_ready !== !exp_i) begin
        n_fail++;
        $display("FAIL starve_c%0d irdy=%b drdy=%b want %b %b",
                 k, i_req_ready, d_req_ready, exp_i, !exp_i);
      end
      if (k < 9) step();
    end
    @(posedge clk);
    #1;
    hs_off = 1'b1;
    idle_inputs();
    step();
    step();
    hs_off = 1'b0;
  endtask

  task automatic test_reset_midflight();
    hs_off = 1'b1;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    d_req_addr   = 32'h44;
    d_req_funct3 = 3'b010;
    @(negedge clk);
    n_chk++;
    if (d_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_grant rdy=%b want 1", d_req_ready);
    end
    step();
    areset_n    = 1'b0;
    d_req_we    = 1'b1;
    d_req_wdata = 32'h12345678;
    i_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if ({i_req_ready, d_req_ready, mem_en, mem_we} !== 4'b0000) begin
        n_fail++;
        $display("FAIL rmid_hold%0d got=%b want 0000",
                 k, {i_req_ready, d_req_ready, mem_en, mem_we});
      end
      if (k > 0) begin
        n_chk++;
        if (d_rsp_valid !== 1'b0 || i_rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rmid_rsp%0d dv=%b iv=%b want 0 0",
                   k, d_rsp_valid, i_rsp_valid);
        end
      end
      step();
    end
    idle_inputs();
    areset_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (d_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_release dv=%b want 0", d_rsp_valid);
    end
    step();
    hs_off = 1'b0;
  endtask

  task automatic test_idle();
    idle_inputs();
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (mem_en !== 1'b0 || i_rsp_valid !== 1'b0 ||
          d_rsp_valid !== 1'b0 || mem_addr !== 32'h0) begin
        n_fail++;
        $display("FAIL idle%0d en=%b iv=%b dv=%b a=%h want 0 0 0 0",
                 k, mem_en, i_rsp_valid, d_rsp_valid, mem_addr);
      end
      step();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    hs_off = 1'b1;
    test_reset();
    test_fetch_only();
    test_collision();
    test_store();
    test_starvation();
    test_reset_midflight();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one single-ported, synchronous-read memory (a `generic_memory` instance) between the instruction-fetch path and the load/store path. It enables a unified instruction/data memory and is the prerequisite for the multi-cycle and pipelined cores. Each requester has a valid/ready request channel and a non-back-pressurable response channel. Data accesses take priority over fetches, with a compile-time anti-starvation guard for fetches.

## Interface
- `STARVE_LIMIT`, 4, max consecutive data grants while a fetch is pending (guard builds only); legal range 1–15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `areset_n`  in  1  reset, synchronous and active-low.
- `i_req_valid`  in  1  fetch request valid.
- `i_req_ready`  out  1  fetch request granted this cycle.
- `i_req_addr`  in  XLEN  fetch byte address.
- `i_rsp_valid`  out  1  fetch read data valid.
- `i_rsp_data`  out  XLEN  fetch read data.
- `d_req_valid`  in  1  data request valid.
- `d_req_ready`  out  1  data request granted this cycle.
- `d_req_we`  in  1  1 = store, 0 = load.
- `d_req_addr`  in  XLEN  data byte address.
- `d_req_wdata`  in  XLEN  store data.
- `d_req_funct3`  in  3  access size/sign, passed through to memory.
- `d_rsp_valid`  out  1  load data valid, or store completion.
- `d_rsp_data`  out  XLEN  load data; 0 for stores.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  XLEN  memory address.
- `mem_wdata`  out  XLEN  memory write data.
- `mem_funct3`  out  3  memory funct3; a fetch drives 3'b010 (word).
- `mem_rdata`  in  XLEN  memory read data, valid one cycle after `mem_en`.

## Operation
- **Grant (combinational).** When `areset_n` is 1:
  - `d_req_ready = d_req_valid & !guard_hit`
  - `i_req_ready = i_req_valid & (!d_req_valid | guard_hit)`
  - At most one ready per cycle.
- **Handshake.** A request is accepted at a rising edge where valid & ready are both 1.
  - The requester holds valid and payload stable until accepted.
  - A bench assertion checks this; the arbiter does not check it.
- **Memory mux.** `mem_*` follows the granted requester in the same cycle. With no grant: `mem_en = 0`, `mem_we = 0`, and addr/wdata/funct3 are 0.
- **Owner register `rsp_owner`** (typedef `arb_owner_e`: `OWN_NONE`, `OWN_I`, `OWN_D`):
  - Loaded on every edge with the owner of that cycle's grant, or `OWN_NONE` if there was no grant.
  - Also records `we` for the data grant.
- **Response.**
  - `i_rsp_valid = (rsp_owner == OWN_I)`.
  - `d_rsp_valid = (rsp_owner == OWN_D)`.
  - `i_rsp_data = mem_rdata` when `OWN_I`, else 0.
  - `d_rsp_data = mem_rdata` for a load, 0 for a store or when not `OWN_D`.
  - Responses cannot be stalled. Each requester consumes exactly one response per accepted request.
- **Back-to-back.** A new grant may issue in the same cycle a response returns, so sustained throughput is 1 access/cycle.
- **Priority.** Data wins a simultaneous request, except when `guard_hit` is set.

## Timing
- **Reset** (`areset_n` low at an edge):
  - `rsp_owner = OWN_NONE` and `streak_cnt = 0`.
  - Both ready outputs, both rsp_valid outputs and `mem_en` read 0 from the next cycle on.
  - While `areset_n` is low, ready outputs and `mem_en` are forced to 0 combinationally.
- **Reset mid-operation.** An in-flight response is dropped, with no `rsp_valid` after reset. A store granted in the reset cycle is not issued.
- **Latency.** Request accepted at edge N → `rsp_valid` high for exactly one cycle between edges N and N+1, sampled at edge N+1.
- **No outstanding limit** beyond the one-deep response pipeline.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - `streak_cnt` (width `$clog2(STARVE_LIMIT+1)`) increments on each data grant made while `i_req_valid` = 1.
  - It clears on a fetch grant, or on any cycle with `i_req_valid` = 0.
  - `guard_hit = (streak_cnt == STARVE_LIMIT) & i_req_valid`.
  - The counter saturates and never wraps.
- Not defined: `guard_hit` is constant 0, `streak_cnt` is absent, and arbitration is strict data priority. `STARVE_LIMIT` is then ignored.

## Structure
- Add to `rv32i_pkg`:
  - typedef `arb_owner_e` (2-bit enum);
  - constant `ARB_FETCH_FUNCT3 = 3'b010`;
  - `XLEN` (already present).
- One sub-module, `mem_arb_starve_counter` (streak counter plus `guard_hit`), instantiated only under `MEM_ARB_STARVE_GUARD_EN`.
- Grant logic, memory mux and owner register stay in `mem_port_arbiter`.

## Test plan
- **Fetch only.** `i_req_valid` = 1 for 3 cycles with addrs 0x0, 0x4, 0x8, memory returning addr+0x100 → `i_rsp_data` = 0x100, 0x104, 0x108 on consecutive cycles, each one cycle after its grant.
- **Collision.** Both valid in one cycle, load from 0x40 → `d_req_ready` = 1 and `i_req_ready` = 0. Fetch is granted the next cycle; `d_rsp_valid` precedes `i_rsp_valid` by one cycle.
- **Store.** Store of 0xDEADBEEF to 0x80 with funct3 = 3'b010 → `mem_we` = 1, `mem_wdata` = 0xDEADBEEF in the grant cycle. Next cycle `d_rsp_valid` = 1 and `d_rsp_data` = 0.
- **Starvation** (guard built, `STARVE_LIMIT` = 4). Both valid continuously → 4 data grants, then 1 fetch grant, repeating. Without the guard: 0 fetch grants.
- **Reset mid-flight.** Load granted at edge N, `areset_n` = 0 sampled at edge N+1 → `d_rsp_valid` stays 0 after N+1, and no ready or `mem_en` is asserted while reset is held.
- **Idle.** No valids for 5 cycles → `mem_en` = 0, both `rsp_valid` = 0, and `mem_addr` = 0 throughout.
